prog_ram: RTL and testbench
===========================

# prog_ram

Parametrised single-clock program/data RAM for the 8-bit processor, the successor to the fixed 31×8 memory. It adds configurable width and depth, a synchronous reset for control state, address-range checking and a streaming loader port that writes a program image sequentially before the CPU runs. The block sits between the CPU memory bus and the board-level program loader.

## Interface
- DATA_W, 8: word width in bits.
- ADDR_W, 8: CPU and loader address width.
- DEPTH, 31: number of words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W.
- WRITE_THROUGH, 0: 1 means a CPU write also drives `data` onto `q`; 0 means `q` holds during a write.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- wren  in  1  CPU write enable.
- address  in  ADDR_W  CPU word address.
- data  in  DATA_W  CPU write data.
- q  out  DATA_W  registered CPU read data.
- addr_err  out  1  one-cycle pulse: the CPU access in the previous cycle had address ≥ DEPTH.
- ld_start  in  1  one-cycle request to begin a load at address 0.
- ld_valid  in  1  loader byte valid.
- ld_data  in  DATA_W  loader byte.
- ld_last  in  1  marks the final loader byte.
- ld_ready  out  1  the block accepts loader bytes (state LOAD).
- busy  out  1  a load is in progress, from LOAD entry to DONE inclusive.
- done  out  1  one-cycle pulse when the load completes.

## Operation
- Storage is not reset. Power-up image comes from the package constant `PROG_RAM_INIT`:
  - addresses 0–10 hold 02 E7 03 10 0B 10 0E 03 0F 93 04;
  - all other words are 00.
- Reset clears `q`, `addr_err`, `ld_ready`, `busy` and `done` to 0, returns the FSM to IDLE and sets the load pointer to 0.
- CPU port (IDLE only):
  - wren=1 with address < DEPTH: write `data`.
  - wren=0 with address < DEPTH: `q` ← mem[address].
  - wren=1 with WRITE_THROUGH=1: `q` ← `data`; with WRITE_THROUGH=0, `q` holds.
  - address ≥ DEPTH: the write is dropped, a read returns `q` = 0, and `addr_err` pulses.
- FSM states: IDLE, LOAD, DONE.
  - IDLE→LOAD on ld_start=1. The pointer is cleared to 0.
  - In LOAD, `ld_ready`=1. Each cycle with ld_valid & ld_ready writes ld_data to mem[ptr], then ptr increments.
  - LOAD→DONE when the accepted byte has ld_last=1, or ptr = DEPTH−1 (auto-terminate; later bytes are not accepted).
  - DONE→IDLE unconditionally after one cycle. `done`=1 while in DONE.
- During LOAD and DONE, CPU wren is ignored, `q` holds and `addr_err` stays 0.
- ld_start is ignored outside IDLE.
- ld_start and wren in the same IDLE cycle: the CPU access completes, and the FSM enters LOAD.
- Reset mid-load: return to IDLE immediately. Bytes already written persist; later bytes are not written.
- The pointer is ADDR_W bits wide and never wraps, because termination happens at DEPTH−1.

## Timing
- CPU read latency is 1 cycle: address presented at edge n gives `q` valid after edge n+1.
- `addr_err` is registered and aligned with the `q` of the offending access.
- `ld_ready` is registered from state. It rises the cycle after ld_start is sampled and falls the cycle after the final byte is accepted.
- `done` is high exactly one cycle: the cycle after the final accept. `busy` falls together with the DONE→IDLE transition.
- Back-to-back loader bytes are accepted at 1 byte/cycle with no bubbles.

## Structure
- Package `prog_ram_pkg` holds:
  - the `ld_state_t` enum (IDLE, LOAD, DONE);
  - the `PROG_RAM_INIT` image constant;
  - the default DATA_W/ADDR_W/DEPTH constants.
- One sub-module, `prog_ram_loader`, contains the FSM, pointer and handshake, and outputs a write strobe, address and data.
- The top level muxes the loader port and the CPU write port into a single inferred memory array.

## Test plan
- Read after reset, addresses 0, 1, 10, 11 → `q` = 02, E7, 04, 00, each one cycle after the address is presented.
- Write 5A to address 20, then read address 20 → `q` = 5A.
  - WRITE_THROUGH=1: `q` = 5A already on the write cycle.
  - WRITE_THROUGH=0: `q` holds its previous value during the write.
- Access address 31 with DEPTH=31 → write dropped, `q` = 00, `addr_err` pulses once.
- Load sequence: ld_start, then 3 bytes AA BB CC with ld_last on CC.
  - Expect `done` one cycle after CC is accepted.
  - Expect mem[0..2] = AA BB CC and mem[3] = 10 unchanged.
  - A CPU wren to address 0 issued during the load has no effect.
- Load 40 bytes with no ld_last at DEPTH=31 → 31 bytes written, `ld_ready` drops after byte 30, `done` pulses, and bytes 31–39 are not accepted.
- Assert reset after the 2nd loader byte → FSM returns to IDLE and `busy`=0. mem[0..1] hold the new bytes and mem[2] keeps its old value (03).

Source files
------------

// File: rtl/prog_ram_pkg.sv
// Shared types, default geometry and power-up program image for prog_ram.
// Pure declarations: no latency and no backpressure.
package prog_ram_pkg;

    localparam int PROG_RAM_DATA_W = 8;
    localparam int PROG_RAM_ADDR_W = 8;
    localparam int PROG_RAM_DEPTH  = 31;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } ld_state_t;

    // Words beyond the image length power up as zero.
    localparam int PROG_RAM_INIT_LEN = 11;
    localparam logic [7:0] PROG_RAM_INIT [PROG_RAM_INIT_LEN] = '{
        8'h02, 8'hE7, 8'h03, 8'h10, 8'h0B, 8'h10,
        8'h0E, 8'h03, 8'h0F, 8'h93, 8'h04
    };

endpackage

// File: rtl/prog_ram_if.sv
// CPU memory bus plus streaming loader port of prog_ram.
// Bundle only: no latency; the loader is throttled by ld_ready.
interface prog_ram_if
    import prog_ram_pkg::*;
#(
    parameter int DATA_W = PROG_RAM_DATA_W,
    parameter int ADDR_W = PROG_RAM_ADDR_W
);
    logic              wren;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] q;
    logic              addr_err;
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              busy;
    logic              done;

    modport master (
        output wren, address, data, ld_start, ld_valid, ld_data, ld_last,
        input  q, addr_err, ld_ready, busy, done
    );

    modport slave (
        input  wren, address, data, ld_start, ld_valid, ld_data, ld_last,
        output q, addr_err, ld_ready, busy, done
    );

endinterface

// File: rtl/prog_ram_loader.sv
// Load FSM: streams loader bytes into memory from address 0 until ld_last or the top word.
// Write strobe is combinational from the accept; ld_ready/busy/done are registered from next state; 1 byte/cycle.
module prog_ram_loader
    import prog_ram_pkg::*;
#(
    parameter int DATA_W = PROG_RAM_DATA_W,
    parameter int ADDR_W = PROG_RAM_ADDR_W,
    parameter int DEPTH  = PROG_RAM_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              busy,
    output logic              done,
    output logic              idle,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ld_ready_q, ld_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        accept  = ld_valid & ld_ready_q;
        case (state_q)
            IDLE: begin
                if (ld_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    ptr_d = ptr_q + 1'b1;
                    if (ld_last || ptr_q == LAST_PTR) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ld_ready_d = (state_d == LOAD);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            ld_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ld_ready_q <= ld_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ld_ready = ld_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign idle     = (state_q == IDLE);
    assign wr_en    = accept;
    assign wr_addr  = ptr_q;
    assign wr_data  = ld_data;

endmodule

// File: rtl/prog_ram.sv
// Single-port program/data RAM with range checking and a sequential program loader.
// CPU read latency 1 cycle; CPU port is ignored while a load is in progress (LOAD/DONE).
module prog_ram
    import prog_ram_pkg::*;
#(
    parameter int DATA_W        = PROG_RAM_DATA_W,
    parameter int ADDR_W        = PROG_RAM_ADDR_W,
    parameter int DEPTH         = PROG_RAM_DEPTH,
    parameter bit WRITE_THROUGH = 1'b0
) (
    input  logic     clock,
    input  logic     reset,
    prog_ram_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(DEPTH);

    typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

    function automatic mem_t init_image();
        mem_t img = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < PROG_RAM_INIT_LEN) begin
                img[i] = DATA_W'(PROG_RAM_INIT[i]);
            end
        end
        return img;
    endfunction

    // Contents survive reset; only the power-up image is defined.
    mem_t mem_q = init_image();

    logic              idle;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_waddr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_waddr_unused;
    logic              in_range;
    logic              cpu_we;
    logic              mem_we;
    logic [IDX_W-1:0]  cpu_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] q_q, q_d;
    logic              addr_err_q, addr_err_d;

    prog_ram_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_loader (
        .clock    (clock),
        .reset    (reset),
        .ld_start (bus.ld_start),
        .ld_valid (bus.ld_valid),
        .ld_data  (bus.ld_data),
        .ld_last  (bus.ld_last),
        .ld_ready (bus.ld_ready),
        .busy     (bus.busy),
        .done     (bus.done),
        .idle     (idle),
        .wr_en    (ld_we),
        .wr_addr  (ld_waddr),
        .wr_data  (ld_wdata)
    );

    // The pointer stops at DEPTH-1, so its upper bits never select a word.
    assign ld_waddr_unused = ^ld_waddr;

    always_comb begin
        in_range   = ({1'b0, bus.address} < ADDR_LIM);
        cpu_idx    = bus.address[IDX_W-1:0];
        cpu_we     = idle & bus.wren & in_range;
        // A reset edge must not commit a loader byte that arrives with it.
        mem_we     = ~reset & (ld_we | cpu_we);
        mem_idx    = ld_we ? ld_waddr[IDX_W-1:0] : cpu_idx;
        mem_wdata  = ld_we ? ld_wdata : bus.data;
        q_d        = q_q;
        addr_err_d = 1'b0;
        if (idle) begin
            if (!in_range) begin
                q_d        = '0;
                addr_err_d = 1'b1;
            end else if (!bus.wren) begin
                q_d = mem_q[cpu_idx];
            end else if (WRITE_THROUGH) begin
                q_d = bus.data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q        <= '0;
            addr_err_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_idx] <= mem_wdata;
        end
    end

    assign bus.q        = q_q;
    assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_prog_ram.sv
// Directed bench for prog_ram: two instances (write-through off/on) share one stimulus stream.
// Inputs change 1 ns after the rising edge; outputs are checked at that same point.
module tb_prog_ram;
    import prog_ram_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    prog_ram_if #(.DATA_W(8), .ADDR_W(8)) bus0 ();
    prog_ram_if #(.DATA_W(8), .ADDR_W(8)) bus1 ();

    assign bus1.wren     = bus0.wren;
    assign bus1.address  = bus0.address;
    assign bus1.data     = bus0.data;
    assign bus1.ld_start = bus0.ld_start;
    assign bus1.ld_valid = bus0.ld_valid;
    assign bus1.ld_data  = bus0.ld_data;
    assign bus1.ld_last  = bus0.ld_last;

    prog_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(31), .WRITE_THROUGH(1'b0)) u_dut_wt0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    prog_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(31), .WRITE_THROUGH(1'b1)) u_dut_wt1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        logic       wren;
        logic [7:0] addr;
        logic [7:0] data;
        logic       chk_q;
        logic [7:0] q0;
        logic [7:0] q1;
        logic       err;
    } vec_t;

    vec_t vecs [12];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string name);
        bus0.wren    = 1'b0;
        bus0.address = addr;
        step();
        check(name, {24'd0, bus0.q}, {24'd0, exp});
    endtask

    initial begin
        int accepted;
        int dones;
        logic rdy_before;

        bus0.wren     = 1'b0;
        bus0.address  = '0;
        bus0.data     = '0;
        bus0.ld_start = 1'b0;
        bus0.ld_valid = 1'b0;
        bus0.ld_data  = '0;
        bus0.ld_last  = 1'b0;

        //        wren  addr   data   chk   q0     q1     err
        vecs[0]  = '{1'b0, 8'd0,  8'h00, 1'b1, 8'h02, 8'h02, 1'b0};
        vecs[1]  = '{1'b0, 8'd1,  8'h00, 1'b1, 8'hE7, 8'hE7, 1'b0};
        vecs[2]  = '{1'b0, 8'd10, 8'h00, 1'b1, 8'h04, 8'h04, 1'b0};
        vecs[3]  = '{1'b0, 8'd11, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 8'd20, 8'h5A, 1'b1, 8'h00, 8'h5A, 1'b0};
        vecs[5]  = '{1'b0, 8'd20, 8'h00, 1'b1, 8'h5A, 8'h5A, 1'b0};
        vecs[6]  = '{1'b0, 8'd31, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1};
        vecs[7]  = '{1'b1, 8'd31, 8'h77, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[8]  = '{1'b0, 8'd3,  8'h00, 1'b1, 8'h10, 8'h10, 1'b0};
        vecs[9]  = '{1'b0, 8'd30, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 8'd30, 8'hC3, 1'b1, 8'h00, 8'hC3, 1'b0};
        vecs[11] = '{1'b0, 8'd30, 8'h00, 1'b1, 8'hC3, 8'hC3, 1'b0};

        step();
        step();
        check("reset q wt0", {24'd0, bus0.q}, 32'd0);
        check("reset q wt1", {24'd0, bus1.q}, 32'd0);
        check("reset addr_err", {31'd0, bus0.addr_err}, 32'd0);
        check("reset ld_ready", {31'd0, bus0.ld_ready}, 32'd0);
        check("reset busy", {31'd0, bus0.busy}, 32'd0);
        check("reset done", {31'd0, bus0.done}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            bus0.wren    = vecs[i].wren;
            bus0.address = vecs[i].addr;
            bus0.data    = vecs[i].data;
            step();
            if (vecs[i].chk_q) begin
                check($sformatf("vec%0d q wt0", i), {24'd0, bus0.q}, {24'd0, vecs[i].q0});
                check($sformatf("vec%0d q wt1", i), {24'd0, bus1.q}, {24'd0, vecs[i].q1});
            end
            check($sformatf("vec%0d addr_err", i), {31'd0, bus0.addr_err}, {31'd0, vecs[i].err});
        end
        bus0.wren    = 1'b0;
        bus0.address = 8'd0;

        // Reset arrives with the third loader byte: that byte must not land.
        bus0.ld_start = 1'b1;
        step();
        check("rst-load ld_ready up", {31'd0, bus0.ld_ready}, 32'd1);
        check("rst-load busy up", {31'd0, bus0.busy}, 32'd1);
        bus0.ld_start = 1'b0;
        bus0.ld_valid = 1'b1;
        bus0.ld_data  = 8'h11;
        step();
        bus0.ld_data  = 8'h22;
        step();
        reset         = 1'b1;
        bus0.ld_data  = 8'h33;
        step();
        check("rst-load busy", {31'd0, bus0.busy}, 32'd0);
        check("rst-load ld_ready", {31'd0, bus0.ld_ready}, 32'd0);
        check("rst-load done", {31'd0, bus0.done}, 32'd0);
        reset        = 1'b0;
        bus0.ld_data = 8'h44;
        step();
        bus0.ld_valid = 1'b0;
        rd(8'd0, 8'h11, "rst-load mem0");
        rd(8'd1, 8'h22, "rst-load mem1");
        rd(8'd2, 8'h03, "rst-load mem2");
        rd(8'd3, 8'h10, "rst-load mem3");

        // Three-byte load with a conflicting CPU write that must be ignored.
        bus0.ld_start = 1'b1;
        step();
        check("load ld_ready up", {31'd0, bus0.ld_ready}, 32'd1);
        check("load busy up", {31'd0, bus0.busy}, 32'd1);
        check("load done low", {31'd0, bus0.done}, 32'd0);
        bus0.ld_start = 1'b0;
        bus0.ld_valid = 1'b1;
        bus0.ld_data  = 8'hAA;
        bus0.wren     = 1'b1;
        bus0.address  = 8'd0;
        bus0.data     = 8'h55;
        step();
        check("load q hold wt0", {24'd0, bus0.q}, 32'h10);
        check("load q hold wt1", {24'd0, bus1.q}, 32'h10);
        bus0.ld_data = 8'hBB;
        step();
        bus0.ld_data  = 8'hCC;
        bus0.ld_last  = 1'b1;
        bus0.address  = 8'd31;
        step();
        check("load ld_ready down", {31'd0, bus0.ld_ready}, 32'd0);
        check("load done pulse", {31'd0, bus0.done}, 32'd1);
        check("load busy in done", {31'd0, bus0.busy}, 32'd1);
        check("load addr_err quiet", {31'd0, bus0.addr_err}, 32'd0);
        bus0.ld_valid = 1'b0;
        bus0.ld_last  = 1'b0;
        bus0.wren     = 1'b0;
        step();
        check("load done clears", {31'd0, bus0.done}, 32'd0);
        check("load busy clears", {31'd0, bus0.busy}, 32'd0);
        rd(8'd0, 8'hAA, "load mem0");
        rd(8'd1, 8'hBB, "load mem1");
        rd(8'd2, 8'hCC, "load mem2");
        rd(8'd3, 8'h10, "load mem3");

        // Forty bytes without ld_last: the load stops itself at the top word.
        bus0.ld_start = 1'b1;
        step();
        bus0.ld_start = 1'b0;
        accepted = 0;
        dones    = 0;
        for (int i = 0; i < 40; i++) begin
            bus0.ld_valid = 1'b1;
            bus0.ld_data  = 8'(8'h80 + i);
            rdy_before    = bus0.ld_ready;
            step();
            if (rdy_before) accepted++;
            if (bus0.done) dones++;
            if (i == 30) begin
                check("auto ld_ready after byte30", {31'd0, bus0.ld_ready}, 32'd0);
                check("auto done after byte30", {31'd0, bus0.done}, 32'd1);
            end
        end
        bus0.ld_valid = 1'b0;
        check("auto accepted count", accepted, 32'd31);
        check("auto done pulses", dones, 32'd1);
        check("auto busy idle", {31'd0, bus0.busy}, 32'd0);
        rd(8'd0,  8'h80, "auto mem0");
        rd(8'd29, 8'h9D, "auto mem29");
        rd(8'd30, 8'h9E, "auto mem30");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
